irq_sched: RTL and testbench

- Interrupt scheduler between the interrupt sources and the CPU's hardware-interrupt input.
- Sources are the timer IRQs and the external interrupt pin.
- Per source: latches the request, applies a mask, and picks the highest-priority pending source.
- Presents one request plus a source ID to the CPU and holds it through an ack / end-of-interrupt (EOI) handshake.
- Memory-mapped behind the bridge as a 4-word device.

---
 rtl/irq_sched.sv | 174 +++++++++++++++++
 tb/tb_irq_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : irq_sched
// Purpose  : Interrupt scheduler between the timer/external IRQ sources and
//            the CPU hardware-interrupt input. Each source is latched into a
//            pending bit (edge or level mode), masked, and the lowest-index
//            eligible source is presented to the CPU. The request is held
//            through an ack / end-of-interrupt handshake. Register access is
//            through a 4-word bridge window (MASK, PEND, MODE, STAT).
// Ports    : clk, reset        - clock, synchronous active-high reset
//            src[N_SRC]        - raw interrupt requests (bit 0 = top priority)
//            Addr/WE/Din/Dout  - bridge register port (Addr[1:0] = word sel)
//            irq, irq_id       - request and source ID to the CPU
//            int_ack, int_eoi  - CPU take / handler-done pulses
//            busy              - a source is in service
// Options  : define IRQ_SCHED_SYNC_EN to pass src through a 2-flop
//            synchronizer (src-to-irq latency 4 cycles instead of 2).
// Revision : 1.0 - initial release
// ============================================================================
module irq_sched #(
  parameter int N_SRC = 6,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [29:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             int_ack,
  input  logic             int_eoi,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_SRC-1:0] mask_q, mode_q, pend_q, pend_d, src_prev_q;
  logic [N_SRC-1:0] src_s, src_edge, w1c, ack_clr, eligible;
  logic [ID_W-1:0]  isr_q, winner;
  logic             unused_ok;

  // Only Addr[1:0] (word address bits [3:2]) is decoded and only the low
  // N_SRC bits of Din reach a register.
  assign unused_ok = ^{Addr[29:2], Din[31:N_SRC]};

`ifdef IRQ_SCHED_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  // Sources are already synchronous to clk.
  assign src_s = src;
`endif

  assign eligible = pend_q & mask_q;

  // Fixed priority: scan from the top so the lowest set index wins.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // Next pending state. Edge bits: a fresh rising edge wins over both the
  // bridge W1C and the ack clear, which are OR'd together. Level bits simply
  // follow the (possibly synchronized) source.
  always_comb begin
    w1c      = (WE && Addr[1:0] == 2'd1) ? Din[N_SRC-1:0] : '0;
    ack_clr  = '0;
    src_edge = src_s & ~src_prev_q;
    if (state_q == S_REQ && int_ack) begin
      for (int i = 0; i < N_SRC; i++) begin
        ack_clr[i] = (irq_id == ID_W'(i)) & mode_q[i];
      end
    end
    pend_d = (mode_q & ((pend_q & ~(w1c | ack_clr)) | src_edge))
           | (~mode_q & src_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= '0;
      mode_q     <= '1;
      pend_q     <= '0;
      src_prev_q <= '0;
    end else begin
      pend_q     <= pend_d;
      src_prev_q <= src_s;
      if (WE && Addr[1:0] == 2'd0) mask_q <= Din[N_SRC-1:0];
      if (WE && Addr[1:0] == 2'd2) mode_q <= Din[N_SRC-1:0];
    end
  end

  // Handshake FSM with registered outputs. An ack in REQ takes precedence
  // over a simultaneous loss of eligibility: the CPU has already committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      irq     <= 1'b0;
      irq_id  <= '0;
      busy    <= 1'b0;
      isr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (eligible != '0) begin
            state_q <= S_REQ;
            irq     <= 1'b1;
            irq_id  <= winner;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            state_q <= S_SERVICE;
            isr_q   <= irq_id;
            irq     <= 1'b0;
            busy    <= 1'b1;
          end else if (eligible == '0) begin
            state_q <= S_IDLE;
            irq     <= 1'b0;
          end else begin
            irq_id  <= winner;   // allows preemption before ack
          end
        end
        S_SERVICE: begin
          if (int_eoi) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          irq     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[1:0])
      2'd0: Dout[N_SRC-1:0] = mask_q;
      2'd1: Dout[N_SRC-1:0] = pend_q;
      2'd2: Dout[N_SRC-1:0] = mode_q;
      default: begin
        Dout[ID_W-1:0] = isr_q;
        Dout[8]        = busy;
        Dout[9]        = irq;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_sched
// Purpose  : Self-checking bench for irq_sched. A behavioural model predicts
//            irq / irq_id / busy / Dout every cycle; directed scenarios add
//            hand-computed expectations, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_sched;

  localparam int N = 6;
  localparam logic [7:0] NMASK = 8'h3F;
`ifdef IRQ_SCHED_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  src = '0;
  logic [29:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        irq;
  logic [2:0]  irq_id;
  logic        int_ack = 1'b0;
  logic        int_eoi = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  irq_sched #(.N_SRC(N), .ID_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq     (irq),
    .irq_id  (irq_id),
    .int_ack (int_ack),
    .int_eoi (int_eoi),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
  int       m_st;
  bit [7:0] m_mask, m_pend, m_mode, m_prev;
  bit [2:0] m_isr, m_id;
  bit       m_irq, m_busy, m_valid = 1'b0;
`ifdef IRQ_SCHED_SYNC_EN
  bit [7:0] m_s1, m_s2;
`endif

  always @(posedge clk) begin : model
    bit [7:0] ss, elig, w1c, ackc, np;
    int win;
    if (reset) begin
      m_mask = 0; m_pend = 0; m_mode = NMASK; m_prev = 0; m_isr = 0;
      m_st = M_IDLE; m_irq = 0; m_id = 0; m_busy = 0; m_valid = 1'b1;
`ifdef IRQ_SCHED_SYNC_EN
      m_s1 = 0; m_s2 = 0;
`endif
    end else begin
`ifdef IRQ_SCHED_SYNC_EN
      ss = m_s2;
      m_s2 = m_s1;
      m_s1 = {2'b0, src};
`else
      ss = {2'b0, src};
`endif
      elig = m_pend & m_mask;
      win = -1;
      for (int i = 0; i < N; i++) if (elig[i] && win < 0) win = i;
      ackc = 0;
      case (m_st)
        M_IDLE: if (win >= 0) begin m_st = M_REQ; m_irq = 1; m_id = 3'(win); end
        M_REQ: begin
          if (int_ack) begin
            m_isr = m_id;
            if (m_mode[m_id]) ackc[m_id] = 1'b1;
            m_st = M_SVC; m_irq = 0; m_busy = 1;
          end else if (win < 0) begin
            m_st = M_IDLE; m_irq = 0;
          end else m_id = 3'(win);
        end
        default: if (int_eoi) begin m_st = M_IDLE; m_busy = 0; end
      endcase
      w1c = (WE && Addr[1:0] == 2'd1) ? Din[7:0] : 8'h0;
      np = 0;
      for (int i = 0; i < N; i++) begin
        if (!m_mode[i])                 np[i] = ss[i];
        else if (ss[i] && !m_prev[i])   np[i] = 1'b1;
        else                            np[i] = m_pend[i] && !w1c[i] && !ackc[i];
      end
      if (WE && Addr[1:0] == 2'd0) m_mask = Din[7:0] & NMASK;
      if (WE && Addr[1:0] == 2'd2) m_mode = Din[7:0] & NMASK;
      m_pend = np;
      m_prev = ss;
    end
  end

  function automatic logic [31:0] exp_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {24'b0, m_mask};
      2'd1:    return {24'b0, m_pend};
      2'd2:    return {24'b0, m_mode};
      default: return {22'b0, m_irq, m_busy, 5'b0, m_isr};
    endcase
  endfunction

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("m_irq",  32'(irq),  32'(m_irq));
      check("m_busy", 32'(busy), 32'(m_busy));
      if (m_irq) check("m_irq_id", 32'(irq_id), 32'(m_id));
      check("m_dout", Dout, exp_dout(Addr[1:0]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'b0, a}; Din = d; WE = 1'b1;
    cyc();
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    Addr = {28'b0, a};
    #1;
    check(name, Dout, exp);
  endtask

  task automatic pulse(input logic [5:0] s);
    src = s;
    cyc();
    src = '0;
    repeat (SYNC) cyc();
  endtask

  task automatic ack();
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
  endtask

  task automatic eoi();
    int_eoi = 1'b1; cyc(); int_eoi = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc();
    reset = 1'b0;
    // Reset state
    check("rst_irq",  32'(irq),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rd(2'd0, 32'h0,  "rst_mask");
    rd(2'd1, 32'h0,  "rst_pend");
    rd(2'd2, 32'h3F, "rst_mode");
    rd(2'd3, 32'h0,  "rst_stat");

    // 1. Basic edge interrupt
    wr(2'd0, 32'h3F);
    pulse(6'h02);
    rd(2'd1, 32'h02, "t1_pend");
    check("t1_irq_early", 32'(irq), 32'd0);
    cyc();
    check("t1_irq", 32'(irq), 32'd1);
    check("t1_id",  32'(irq_id), 32'd1);
    ack();
    check("t1_irq_ack",  32'(irq),  32'd0);
    check("t1_busy_ack", 32'(busy), 32'd1);
    rd(2'd1, 32'h0, "t1_pend_ack");
    eoi();
    check("t1_busy_eoi", 32'(busy), 32'd0);
    rd(2'd3, 32'h001, "t1_stat");

    // 2. Priority and preemption before ack
    pulse(6'h10);
    cyc();
    check("t2_id4", 32'(irq_id), 32'd4);
    cyc();
    pulse(6'h04);
    cyc();
    check("t2_id2", 32'(irq_id), 32'd2);
    ack();
    rd(2'd3, 32'h102, "t2_stat_svc");
    rd(2'd1, 32'h10,  "t2_pend4");
    eoi();
    cyc();
    check("t2_irq_re", 32'(irq),    32'd1);
    check("t2_id_re",  32'(irq_id), 32'd4);
    ack(); eoi();

    // 3. Masking
    wr(2'd0, 32'h00);
    pulse(6'h01);
    cyc(); cyc();
    check("t3_irq_masked", 32'(irq), 32'd0);
    rd(2'd1, 32'h01, "t3_pend");
    wr(2'd0, 32'h01);
    check("t3_irq_wr", 32'(irq), 32'd0);
    cyc();
    check("t3_irq", 32'(irq),    32'd1);
    check("t3_id",  32'(irq_id), 32'd0);
    ack(); eoi();

    // 4. Level mode
    wr(2'd2, 32'h3E);
    src = 6'h01;
    cyc();
    repeat (SYNC) cyc();
    wr(2'd1, 32'h01);
    rd(2'd1, 32'h01, "t4_pend_w1c");
    check("t4_irq", 32'(irq), 32'd1);
    ack(); eoi();
    cyc();
    check("t4_irq_re", 32'(irq),    32'd1);
    check("t4_id_re",  32'(irq_id), 32'd0);
    src = 6'h00;
    cyc();
    repeat (SYNC) cyc();
    rd(2'd1, 32'h00, "t4_pend_drop");
    cyc();
    check("t4_irq_drop", 32'(irq), 32'd0);
    wr(2'd2, 32'h3F);

    // 5. Simultaneous set and clear
    wr(2'd0, 32'h00);
    src = 6'h08;
    repeat (SYNC) cyc();
    Addr = 30'd1; Din = 32'h08; WE = 1'b1;
    cyc();
    WE = 1'b0; src = 6'h00;
    rd(2'd1, 32'h08, "t5_set_wins");
    wr(2'd1, 32'h08);
    rd(2'd1, 32'h00, "t5_w1c");

    // 6. Reset in SERVICE
    wr(2'd0, 32'h3F);
    pulse(6'h20);
    cyc();
    ack();
    check("t6_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_irq_rst",  32'(irq),  32'd0);
    rd(2'd0, 32'h00, "t6_mask");
    rd(2'd2, 32'h3F, "t6_mode");
    rd(2'd1, 32'h00, "t6_pend");
    eoi();
    check("t6_busy_eoi", 32'(busy), 32'd0);
    rd(2'd3, 32'h000, "t6_stat");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 299) == 0);
      src     = src ^ 6'($urandom & $urandom & $urandom);
      WE      = ($urandom_range(0, 5) == 0);
      Addr    = 30'($urandom);
      Din     = $urandom;
      int_ack = ($urandom_range(0, 2) == 0);
      int_eoi = ($urandom_range(0, 3) == 0);
      cyc();
    end
    reset = 1'b0; WE = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
